pc_dispatcher: RTL and testbench

PC_DISPATCHER -- requirements
Module: pc_dispatcher

---
 rtl/pc_dispatcher_if.sv | 42 ++++
 rtl/pc_dispatcher.sv | 152 +++++++++++++++
 tb/tb_pc_dispatcher.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/pc_dispatcher_if.sv
`default_nettype none
// ============================================================================
// Module   : pc_dispatcher_if
// Brief    : Seed / inbound PC / outbound PC handshakes of the PC dispatcher.
//            slave = the dispatcher, master = its environment.
// Revision : 1.0 - initial release
// ============================================================================
interface pc_dispatcher_if #(
  parameter int PC_WIDTH = 8
);
  logic                seed_valid;
  logic [PC_WIDTH-1:0] seed_pc;
  logic                seed_ready;

  logic                in_pc_valid;
  logic [PC_WIDTH-1:0] in_pc;
  logic                in_pc_is_directed_to_current;
  logic                in_pc_ready;

  logic                out_pc_valid;
  logic [PC_WIDTH-1:0] out_pc;
  logic                out_pc_ready;

  modport master (
    output seed_valid, seed_pc,
    input  seed_ready,
    output in_pc_valid, in_pc, in_pc_is_directed_to_current,
    input  in_pc_ready,
    input  out_pc_valid, out_pc,
    output out_pc_ready
  );

  modport slave (
    input  seed_valid, seed_pc,
    output seed_ready,
    input  in_pc_valid, in_pc, in_pc_is_directed_to_current,
    output in_pc_ready,
    output out_pc_valid, out_pc,
    input  out_pc_ready
  );
endinterface
`default_nettype wire

// File: rtl/pc_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : pc_dispatcher
// Brief    : Two-bank PC scheduler for a character-stepped matcher. The bank
//            selected by sel holds threads for the current character, the
//            other bank collects threads for the next character.
// Revision : 1.0 - initial release
// ============================================================================
module pc_dispatcher #(
  parameter int PC_WIDTH        = 8,
  parameter int FIFO_DEPTH_LOG2 = 3
) (
  input  wire logic        clk,
  input  wire logic        reset,
  pc_dispatcher_if.slave   bus,
  input  wire logic        bb_busy,
  input  wire logic        last_character,
  output logic             advance_character,
  output logic             done,
  output logic             running,
  output logic             overflow
);

  localparam int C_DEPTH = 1 << FIFO_DEPTH_LOG2;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t              r_state;
  logic                r_sel;
  logic                r_seed_ready;
  logic                r_overflow;

  logic [1:0]          w_full;
  logic [1:0]          w_empty;
  logic [1:0]          w_push;
  logic [1:0]          w_pop;
  logic [PC_WIDTH-1:0] w_head [2];

  logic                w_run;
  logic                w_seed_acc;
  logic                w_in_acc;
  logic                w_out_acc;
  logic                w_quiet;
  logic                w_overflow_evt;

  // Handshake decode. done/advance are decoded from registered state and
  // counts so they land in the quiescent cycle itself; the new CURRENT bank
  // then issues on the very next cycle.
  always_comb begin
    w_run            = (r_state == ST_RUN);
    bus.seed_ready   = r_seed_ready;
    bus.in_pc_ready  = w_run && !w_full[0] && !w_full[1];
    bus.out_pc_valid = w_run && !w_empty[r_sel];
    bus.out_pc       = w_head[r_sel];
    w_seed_acc       = (r_state == ST_IDLE) && bus.seed_valid && r_seed_ready;
    w_in_acc         = bus.in_pc_valid && bus.in_pc_ready;
    w_out_acc        = bus.out_pc_valid && bus.out_pc_ready;
    w_quiet          = w_run && w_empty[r_sel] && !bb_busy && !bus.in_pc_valid;
    done             = w_quiet && (w_empty[~r_sel] || last_character);
    advance_character = w_quiet && !w_empty[~r_sel] && !last_character;
    running          = w_run;
    overflow         = r_overflow;
    w_overflow_evt   = (w_push[0] && w_full[0]) || (w_push[1] && w_full[1]);
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    logic [PC_WIDTH-1:0]        r_mem [C_DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] r_wr_ptr;
    logic [FIFO_DEPTH_LOG2-1:0] r_rd_ptr;
    logic [FIFO_DEPTH_LOG2:0]   r_cnt;
    logic                       w_push_ok;
    logic                       w_is_cur;
    logic [PC_WIDTH-1:0]        w_data;

    // Route seeds and directed PCs into this bank; a full bank drops the push.
    always_comb begin
      w_is_cur  = (r_sel == 1'(b));
      w_push[b] = (w_seed_acc && w_is_cur) ||
                  (w_in_acc && (bus.in_pc_is_directed_to_current ? w_is_cur : !w_is_cur));
      w_pop[b]  = w_out_acc && w_is_cur;
      w_full[b] = (r_cnt == (FIFO_DEPTH_LOG2+1)'(C_DEPTH));
      w_empty[b] = (r_cnt == '0);
      w_push_ok = w_push[b] && !w_full[b];
      w_data    = w_seed_acc ? bus.seed_pc : bus.in_pc;
      w_head[b] = r_mem[r_rd_ptr];
    end

    // Storage array, written only on an accepted push.
    always_ff @(posedge clk) begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= w_data;
      end
    end

    // Pointers and occupancy; a done pulse flushes whatever is left.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_cnt    <= '0;
      end else if (done) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_cnt    <= '0;
      end else begin
        if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop[b])  r_rd_ptr <= r_rd_ptr + 1'b1;
        if (w_push_ok && !w_pop[b])      r_cnt <= r_cnt + 1'b1;
        else if (!w_push_ok && w_pop[b]) r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  // Control FSM: seed intake, character stepping and the sticky overflow flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_sel        <= 1'b0;
      r_seed_ready <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_overflow <= r_overflow | w_overflow_evt;
      case (r_state)
        ST_IDLE: begin
          if (w_seed_acc) begin
            r_state      <= ST_RUN;
            r_seed_ready <= 1'b0;
          end else begin
            r_seed_ready <= 1'b1;
          end
        end
        ST_RUN: begin
          if (done) begin
            r_state      <= ST_IDLE;
            r_seed_ready <= 1'b1;
          end else if (advance_character) begin
            r_sel <= ~r_sel;
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_seed_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pc_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_dispatcher
// Brief    : Self-checking bench for pc_dispatcher against a queue-based model
//            of the current/next thread lists.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_dispatcher;

  localparam int PC_WIDTH = 8;
  localparam int DEPTH    = 8;

  logic clk = 1'b0;
  logic reset;
  logic bb_busy, last_character;
  logic advance_character, done, running, overflow;

  pc_dispatcher_if #(.PC_WIDTH(PC_WIDTH)) bus ();

  pc_dispatcher #(.PC_WIDTH(PC_WIDTH), .FIFO_DEPTH_LOG2(3)) dut (
    .clk               (clk),
    .reset             (reset),
    .bus               (bus),
    .bb_busy           (bb_busy),
    .last_character    (last_character),
    .advance_character (advance_character),
    .done              (done),
    .running           (running),
    .overflow          (overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: two thread lists, a run flag and the seed-ready flag.
  logic [PC_WIDTH-1:0] cur_q[$];
  logic [PC_WIDTH-1:0] nxt_q[$];
  bit m_run;
  bit m_sr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input bit sv, input logic [7:0] spc, input bit iv, input logic [7:0] ipc,
                       input bit dir, input bit ordy, input bit bb, input bit last);
    bus.seed_valid = sv;  bus.seed_pc = spc;
    bus.in_pc_valid = iv; bus.in_pc = ipc; bus.in_pc_is_directed_to_current = dir;
    bus.out_pc_ready = ordy; bb_busy = bb; last_character = last;
  endtask

  task automatic model_reset();
    cur_q.delete(); nxt_q.delete(); m_run = 0; m_sr = 0;
  endtask

  // Compare every output with the model for the present inputs, then advance
  // the model across the coming clock edge.
  task automatic step();
    bit e_ov, e_ir, quiet, e_done, e_adv;
    #2;
    e_ov   = m_run && (cur_q.size() != 0);
    e_ir   = m_run && (cur_q.size() < DEPTH) && (nxt_q.size() < DEPTH);
    quiet  = m_run && (cur_q.size() == 0) && !bb_busy && !bus.in_pc_valid;
    e_done = quiet && ((nxt_q.size() == 0) || last_character);
    e_adv  = quiet && (nxt_q.size() != 0) && !last_character;
    chk("seed_ready", bus.seed_ready, m_sr);
    chk("out_pc_valid", bus.out_pc_valid, e_ov);
    if (e_ov) chk("out_pc", bus.out_pc, cur_q[0]);
    chk("in_pc_ready", bus.in_pc_ready, e_ir);
    chk("done", done, e_done);
    chk("advance", advance_character, e_adv);
    chk("running", running, m_run);
    chk("overflow", overflow, 0);
    if (!m_run) begin
      if (bus.seed_valid && m_sr) begin
        cur_q.push_back(bus.seed_pc);
        m_run = 1;
      end
    end else begin
      if (e_ov && bus.out_pc_ready) void'(cur_q.pop_front());
      if (bus.in_pc_valid && e_ir) begin
        if (bus.in_pc_is_directed_to_current) cur_q.push_back(bus.in_pc);
        else nxt_q.push_back(bus.in_pc);
      end
      if (e_done) begin
        cur_q.delete(); nxt_q.delete(); m_run = 0;
      end else if (e_adv) begin
        cur_q = nxt_q; nxt_q.delete();
      end
    end
    m_sr = !m_run;
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #1;
    chk("rst_seed_ready", bus.seed_ready, 0);
    chk("rst_in_ready", bus.in_pc_ready, 0);
    chk("rst_out_valid", bus.out_pc_valid, 0);
    chk("rst_done", done, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    step();
    #1 chk("seed_ready_after_rst", bus.seed_ready, 1);

    // Single seed, no children: issue then done.
    drive(1, 8'h12, 0, 0, 0, 1, 0, 0); step();
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    #1 chk("a_out_valid", bus.out_pc_valid, 1);
    chk("a_out_pc", bus.out_pc, 8'h12);
    step();
    #1 chk("a_done", done, 1);
    step();
    #1 chk("a_idle_seed_ready", bus.seed_ready, 1);
    chk("a_idle_running", running, 0);
    step();

    // Child PC for next character, then advance.
    drive(1, 8'h12, 0, 0, 0, 1, 1, 0); step();
    drive(0, 0, 0, 0, 0, 1, 1, 0); step();
    drive(0, 0, 1, 8'h13, 0, 1, 1, 0); step();
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    #1 chk("b_advance", advance_character, 1);
    chk("b_no_done", done, 0);
    step();
    #1 chk("b_out_pc", bus.out_pc, 8'h13);
    chk("b_advance_pulse", advance_character, 0);
    repeat (3) step();

    // Fill CURRENT to depth, then drain in order.
    drive(1, 8'h40, 0, 0, 0, 1, 1, 0); step();
    drive(0, 0, 0, 0, 0, 1, 1, 0); step();
    for (int i = 0; i < DEPTH; i++) begin
      drive(0, 0, 1, 8'(8'h50 + i), 1, 0, 1, 0); step();
    end
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    #1 chk("c_in_ready_full", bus.in_pc_ready, 0);
    chk("c_overflow", overflow, 0);
    drive(0, 0, 0, 0, 0, 1, 1, 0);
    for (int i = 0; i < DEPTH; i++) begin
      #1 chk("c_pop_order", bus.out_pc, 8'(8'h50 + i));
      step();
    end
    drive(0, 0, 0, 0, 0, 1, 0, 0); repeat (2) step();

    // Simultaneous pop and push on a one-entry CURRENT.
    drive(1, 8'h60, 0, 0, 0, 0, 1, 0); step();
    drive(0, 0, 1, 8'h20, 1, 1, 1, 0); step();
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    #1 chk("d_out_pc", bus.out_pc, 8'h20);
    chk("d_valid", bus.out_pc_valid, 1);
    drive(0, 0, 0, 0, 0, 1, 1, 0); step();
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    #1 chk("d_count_one", bus.out_pc_valid, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0); repeat (2) step();

    // NEXT non-empty on the last character: done, flush.
    drive(1, 8'h70, 0, 0, 0, 1, 1, 0); step();
    drive(0, 0, 0, 0, 0, 1, 1, 0); step();
    drive(0, 0, 1, 8'h30, 0, 1, 1, 0); step();
    drive(0, 0, 0, 0, 0, 1, 0, 1);
    #1 chk("e_done", done, 1);
    chk("e_no_advance", advance_character, 0);
    step();
    #1 chk("e_running", running, 0);
    drive(1, 8'h71, 0, 0, 0, 0, 1, 0); step();
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    #1 chk("e_flushed", bus.out_pc, 8'h71);
    drive(0, 0, 0, 0, 0, 1, 1, 0); step();
    drive(0, 0, 0, 0, 0, 1, 0, 1); repeat (2) step();

    // Asynchronous reset mid-RUN with three queued PCs.
    drive(1, 8'h01, 0, 0, 0, 0, 1, 0); step();
    drive(0, 0, 1, 8'h02, 1, 0, 1, 0); step();
    drive(0, 0, 1, 8'h03, 1, 0, 1, 0); step();
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    #2 reset = 1'b0;
    model_reset();
    #1;
    chk("f_out_valid", bus.out_pc_valid, 0);
    chk("f_in_ready", bus.in_pc_ready, 0);
    chk("f_seed_ready", bus.seed_ready, 0);
    chk("f_done", done, 0);
    chk("f_advance", advance_character, 0);
    chk("f_overflow", overflow, 0);
    chk("f_running", running, 0);
    @(posedge clk); #1;
    chk("f_hold_seed_ready", bus.seed_ready, 0);
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0); step();
    drive(1, 8'h05, 0, 0, 0, 1, 0, 0); step();
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    #1 chk("f_out_pc", bus.out_pc, 8'h05);
    repeat (3) step();

    // Randomized traffic checked against the model.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 3) == 0, 8'($urandom), $urandom_range(0, 1) == 1, 8'($urandom),
            $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
